// File: rtl/display_arbiter_if.sv
// Display arbiter bus: requester frames in, one arbitrated frame plus grant status out.
// The master side is the set of requesters; the slave side is the arbiter itself.
interface display_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int NUM_DIGITS     = 8
);
  logic [NUM_REQUESTERS-1:0]              request;
  logic [NUM_REQUESTERS*NUM_DIGITS*4-1:0] requestData;
  logic [NUM_REQUESTERS*NUM_DIGITS-1:0]   requestPoints;
  logic [NUM_REQUESTERS-1:0]              grant;
  logic [NUM_DIGITS*4-1:0]                data;
  logic [NUM_DIGITS-1:0]                  pointEnable;
  logic                                   expired;

  modport master (
    output request, requestData, requestPoints,
    input  grant, data, pointEnable, expired
  );

  modport slave (
    input  request, requestData, requestPoints,
    output grant, data, pointEnable, expired
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares one seven-segment display among several
// requesters. An owner keeps the display for at least HOLD_CYCLES while it
// requests; after that it yields as soon as anyone else asks. The owner's
// frame and decimal-point mask are registered so they change on the grant edge.
module display_arbiter #(
  parameter int          NUM_REQUESTERS = 4,
  parameter int          NUM_DIGITS     = 8,
  parameter logic [31:0] HOLD_CYCLES    = 32'd50_000_000
) (
  input logic            clock,
  input logic            reset,
  display_arbiter_if.slave bus
);

  localparam int                IDX_W     = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int                FRAME_W   = NUM_DIGITS * 4;
  localparam logic [31:0]       HOLD_LAST = HOLD_CYCLES - 32'd1;
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, EXPIRED} state_t;

  state_t                    state, stateNext;
  logic [31:0]               holdCount, holdCountNext;
  logic [IDX_W-1:0]          lastOwner, lastOwnerNext;
  logic [NUM_REQUESTERS-1:0] grant_p1, grantNext;
  logic [FRAME_W-1:0]        frame_p1, frameNext;
  logic [NUM_DIGITS-1:0]     points_p1, pointsNext;
  logic [NUM_REQUESTERS-1:0] candidates;
  logic                      winFound;
  logic [IDX_W-1:0]          winIdx;
  logic                      ownerReq;

  // Requester index 'off' positions after base, wrapping modulo NUM_REQUESTERS.
  function automatic logic [IDX_W-1:0] rrIndex(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQUESTERS) sum = sum - NUM_REQUESTERS;
    return IDX_W'(sum);
  endfunction

  // Saturating increment so a very long ownership never wraps the counter.
  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Round-robin search starting just after lastOwner; the current owner is
  // masked so it can never be picked as its own successor.
  always_comb begin
    candidates = bus.request;
    if (state != IDLE) candidates[lastOwner] = 1'b0;
    winFound = 1'b0;
    winIdx   = lastOwner;
    // Scan farthest-first so the nearest hit is the one that sticks.
    for (int off = NUM_REQUESTERS; off >= 1; off--) begin
      if (candidates[rrIndex(lastOwner, off)]) begin
        winFound = 1'b1;
        winIdx   = rrIndex(lastOwner, off);
      end
    end
  end

  assign ownerReq = bus.request[lastOwner];

  // Next state, hold counter, owner index and the frame to register.
  always_comb begin
    stateNext     = state;
    holdCountNext = holdCount;
    lastOwnerNext = lastOwner;
    unique case (state)
      IDLE: begin
        if (winFound) begin
          stateNext     = HOLD;
          holdCountNext = 32'd0;
          lastOwnerNext = winIdx;
        end
      end
      HOLD: begin
        if (ownerReq) begin
          holdCountNext = satInc(holdCount);
          if (holdCount == HOLD_LAST) stateNext = EXPIRED;
        end else if (winFound) begin
          holdCountNext = 32'd0;
          lastOwnerNext = winIdx;
        end else begin
          stateNext     = IDLE;
          holdCountNext = 32'd0;
        end
      end
      EXPIRED: begin
        if (winFound) begin
          stateNext     = HOLD;
          holdCountNext = 32'd0;
          lastOwnerNext = winIdx;
        end else if (ownerReq) begin
          holdCountNext = satInc(holdCount);
        end else begin
          stateNext     = IDLE;
          holdCountNext = 32'd0;
        end
      end
      default: begin
        stateNext     = IDLE;
        holdCountNext = 32'd0;
      end
    endcase

    grantNext  = '0;
    frameNext  = '0;
    pointsNext = '0;
    if (stateNext != IDLE) begin
      grantNext[lastOwnerNext] = 1'b1;
      frameNext  = bus.requestData[int'(lastOwnerNext)*FRAME_W +: FRAME_W];
      pointsNext = bus.requestPoints[int'(lastOwnerNext)*NUM_DIGITS +: NUM_DIGITS];
    end
  end

  // State, counter and registered display outputs; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      holdCount <= 32'd0;
      lastOwner <= LAST_INIT;
      grant_p1  <= '0;
      frame_p1  <= '0;
      points_p1 <= '0;
    end else begin
      state     <= stateNext;
      holdCount <= holdCountNext;
      lastOwner <= lastOwnerNext;
      grant_p1  <= grantNext;
      frame_p1  <= frameNext;
      points_p1 <= pointsNext;
    end
  end

  assign bus.grant       = grant_p1;
  assign bus.data        = frame_p1;
  assign bus.pointEnable = points_p1;
  assign bus.expired     = (state == EXPIRED);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: 4 requesters, 8 digits, hold of 4 cycles,
// plus a second instance with a hold of 1 cycle.
module tb_display_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  display_arbiter_if #(.NUM_REQUESTERS(4), .NUM_DIGITS(8)) bus ();
  display_arbiter_if #(.NUM_REQUESTERS(4), .NUM_DIGITS(8)) bus1 ();

  display_arbiter #(.NUM_REQUESTERS(4), .NUM_DIGITS(8), .HOLD_CYCLES(32'd4)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  display_arbiter #(.NUM_REQUESTERS(4), .NUM_DIGITS(8), .HOLD_CYCLES(32'd1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setFrame(input int i, input logic [31:0] v, input logic [7:0] p);
    bus.requestData[i*32 +: 32] = v;
    bus.requestPoints[i*8 +: 8] = p;
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.request = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.request = 4'b1111;
    for (int i = 0; i < 4; i++) setFrame(i, 32'hDEAD_0000 + 32'(i), 8'hFF);
    tick();
    tick();
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", bus.data); end
    checks++; if (bus.pointEnable !== 8'h00) begin failures++; $display("FAIL reset_points got=%h exp=00", bus.pointEnable); end
    checks++; if (bus.expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", bus.expired); end
    bus.request = 4'b0000;
    reset = 1'b0;
  endtask

  task automatic test_single_owner();
    doReset();
    setFrame(2, 32'h1234_5678, 8'hA5);
    bus.request = 4'b0100;
    tick();
    checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", bus.grant); end
    checks++; if (bus.data !== 32'h1234_5678) begin failures++; $display("FAIL single_data got=%h exp=12345678", bus.data); end
    checks++; if (bus.pointEnable !== 8'hA5) begin failures++; $display("FAIL single_points got=%h exp=a5", bus.pointEnable); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (bus.expired !== (c == 4)) begin failures++; $display("FAIL single_expired c=%0d got=%b exp=%b", c, bus.expired, (c == 4)); end
    end
    for (int c = 0; c < 6; c++) tick();
    checks++; if (bus.grant !== 4'b0100 || bus.expired !== 1'b1) begin failures++; $display("FAIL single_keep got=%b/%b exp=0100/1", bus.grant, bus.expired); end
  endtask

  task automatic test_round_robin();
    logic [3:0] expGrant;
    logic [31:0] expData;
    doReset();
    for (int i = 0; i < 4; i++) setFrame(i, {8{4'(i + 1)}}, 8'(8'h10 << i));
    bus.request = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      expGrant = 4'(1 << (k % 4));
      expData  = {8{4'((k % 4) + 1)}};
      for (int c = 0; c < 5; c++) begin
        checks++; if (bus.grant !== expGrant) begin failures++; $display("FAIL rr_grant k=%0d c=%0d got=%b exp=%b", k, c, bus.grant, expGrant); end
        checks++; if (bus.data !== expData) begin failures++; $display("FAIL rr_data k=%0d c=%0d got=%h exp=%h", k, c, bus.data, expData); end
        checks++; if (bus.expired !== (c == 4)) begin failures++; $display("FAIL rr_expired k=%0d c=%0d got=%b exp=%b", k, c, bus.expired, (c == 4)); end
        tick();
      end
    end
  endtask

  task automatic test_owner_drop();
    doReset();
    bus.request = 4'b0010;
    tick();
    checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL drop_first got=%b exp=0010", bus.grant); end
    tick();
    bus.request = 4'b1001;
    tick();
    checks++; if (bus.grant !== 4'b1000) begin failures++; $display("FAIL drop_switch got=%b exp=1000", bus.grant); end
    checks++; if (bus.expired !== 1'b0) begin failures++; $display("FAIL drop_expired got=%b exp=0", bus.expired); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (bus.expired !== (c == 4)) begin failures++; $display("FAIL drop_restart c=%0d got=%b exp=%b", c, bus.expired, (c == 4)); end
    end
    tick();
    checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL drop_next got=%b exp=0001", bus.grant); end
  endtask

  task automatic test_idle_wrap();
    doReset();
    setFrame(3, 32'hCAFE_F00D, 8'h3C);
    bus.request = 4'b1000;
    tick();
    checks++; if (bus.grant !== 4'b1000 || bus.data !== 32'hCAFE_F00D) begin failures++; $display("FAIL idle_owner3 got=%b/%h exp=1000/cafef00d", bus.grant, bus.data); end
    bus.request = 4'b0000;
    tick();
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL idle_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.data !== 32'h0 || bus.pointEnable !== 8'h00) begin failures++; $display("FAIL idle_frame got=%h/%h exp=0/0", bus.data, bus.pointEnable); end
    tick();
    bus.request = 4'b0001;
    tick();
    checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL idle_wrap got=%b exp=0001", bus.grant); end
  endtask

  task automatic test_reset_mid_hold();
    doReset();
    bus.request = 4'b0100;
    tick();
    bus.request = 4'b1111;
    tick();
    checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL midrst_hold got=%b exp=0100", bus.grant); end
    reset = 1'b1;
    tick();
    checks++; if (bus.grant !== 4'b0000 || bus.data !== 32'h0 || bus.pointEnable !== 8'h00 || bus.expired !== 1'b0) begin
      failures++; $display("FAIL midrst_zero got=%b/%h/%h/%b exp=0000/0/0/0", bus.grant, bus.data, bus.pointEnable, bus.expired);
    end
    reset = 1'b0;
    tick();
    checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL midrst_first got=%b exp=0001", bus.grant); end
  endtask

  task automatic test_data_tracking();
    logic [31:0] vals [6];
    logic [31:0] prev;
    vals = '{32'h0000_0001, 32'h1111_2222, 32'h89AB_CDEF, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h7654_3210};
    doReset();
    setFrame(0, 32'hA0A0_0000, 8'h01);
    bus.request = 4'b0001;
    tick();
    prev = 32'hA0A0_0000;
    for (int i = 0; i < 6; i++) begin
      setFrame(0, vals[i], 8'(i + 2));
      setFrame(1, 32'h5555_0000 + 32'(i), 8'hEE);
      setFrame(2, 32'h6666_0000 + 32'(i), 8'hDD);
      #2;
      checks++; if (bus.data !== prev) begin failures++; $display("FAIL track_hold i=%0d got=%h exp=%h", i, bus.data, prev); end
      tick();
      checks++; if (bus.data !== vals[i]) begin failures++; $display("FAIL track_data i=%0d got=%h exp=%h", i, bus.data, vals[i]); end
      checks++; if (bus.pointEnable !== 8'(i + 2)) begin failures++; $display("FAIL track_points i=%0d got=%h exp=%h", i, bus.pointEnable, 8'(i + 2)); end
      prev = vals[i];
    end
  endtask

  task automatic test_hold_one();
    doReset();
    bus1.requestData[32 +: 32] = 32'h0BAD_BEEF;
    bus1.request = 4'b0010;
    tick();
    checks++; if (bus1.grant !== 4'b0010 || bus1.expired !== 1'b0) begin failures++; $display("FAIL hold1_grant got=%b/%b exp=0010/0", bus1.grant, bus1.expired); end
    tick();
    checks++; if (bus1.expired !== 1'b1) begin failures++; $display("FAIL hold1_expired got=%b exp=1", bus1.expired); end
    bus1.request = 4'b0011;
    tick();
    checks++; if (bus1.grant !== 4'b0001 || bus1.expired !== 1'b0) begin failures++; $display("FAIL hold1_switch got=%b/%b exp=0001/0", bus1.grant, bus1.expired); end
    bus1.request = 4'b0000;
  endtask

  initial begin
    bus.request = '0;
    bus.requestData = '0;
    bus.requestPoints = '0;
    bus1.request = '0;
    bus1.requestData = '0;
    bus1.requestPoints = '0;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_owner_drop();
    test_idle_wrap();
    test_reset_mid_hold();
    test_data_tracking();
    test_hold_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4: number of requesters sharing the display, range 2..8.
REQ-002 SHALL have parameter NUM_DIGITS, default 8: digits per frame, 4 bits per digit.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000: minimum ownership time in clock cycles, range 1..2^32-1.
REQ-004 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port request, input, NUM_REQUESTERS: level request per requester.
REQ-007 SHALL have port requestData, input, NUM_REQUESTERS*NUM_DIGITS*4: frame of requester i in slice [i*NUM_DIGITS*4 +: NUM_DIGITS*4].
REQ-008 SHALL have port requestPoints, input, NUM_REQUESTERS*NUM_DIGITS: decimal-point mask of requester i in slice [i*NUM_DIGITS +: NUM_DIGITS].
REQ-009 SHALL have port grant, output, NUM_REQUESTERS: one-hot current owner, all-zero when idle.
REQ-010 SHALL have port data, output, NUM_DIGITS*4: registered frame for the seven-segment controller.
REQ-011 SHALL have port pointEnable, output, NUM_DIGITS: registered decimal-point mask for the controller.
REQ-012 SHALL have port expired, output, 1: high while owner has held at least HOLD_CYCLES.

Function
REQ-013 SHALL implement states IDLE, HOLD, EXPIRED, with internal holdCount (32 bits) and lastOwner index.
REQ-014 Winner SHALL be chosen round-robin: first asserted request scanning (lastOwner+1) mod N upward with wrap; the current owner is never its own successor.
REQ-015 IDLE: no request -> stay; any request -> grant winner at next edge, holdCount=0, go HOLD.
REQ-016 HOLD: owner request high -> holdCount+1; holdCount==HOLD_CYCLES-1 -> go EXPIRED with expired=1 from next edge.
REQ-017 EXPIRED: owner high, no other request -> keep owner indefinitely; owner high, any other request -> grant winner at next edge, holdCount=0, go HOLD.
REQ-018 Owner dropping request in HOLD or EXPIRED SHALL release at next edge regardless of holdCount: other request pending -> grant winner, HOLD, holdCount=0; none -> IDLE.
REQ-019 lastOwner SHALL update to the new owner index on every grant change; unchanged on entry to IDLE.
REQ-020 Grant changes SHALL be evaluated from requests sampled at the current edge; latency request-to-grant is exactly 1 cycle.
REQ-021 data/pointEnable SHALL be registered every cycle from the slices of the owner that is valid after that edge, so grant and frame change on the same edge.
REQ-022 data/pointEnable SHALL be all-zero in IDLE; an owner's frame updates live (1-cycle latency) while owned.
REQ-023 HOLD_CYCLES==1 SHALL enter EXPIRED one edge after grant.
REQ-024 Simultaneous owner drop and new requests SHALL be resolved by REQ-018 using REQ-014 ordering.
REQ-025 grant SHALL never have more than one bit set; expired SHALL be 0 outside EXPIRED.

Reset
REQ-026 reset high at an edge SHALL force state IDLE, grant=0, data=0, pointEnable=0, expired=0, holdCount=0, lastOwner=NUM_REQUESTERS-1, overriding all other inputs including mid-hold.
REQ-027 First grant after reset with all requests high SHALL go to requester 0.

Verification (NUM_REQUESTERS=4, HOLD_CYCLES=4)
REQ-028 Reset, request=4'b0100, requestData slice2=32'h12345678 -> next edge grant=4'b0100, data=32'h12345678; four edges later expired=1; stays granted while only requester 2 requests.
REQ-029 request=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each held exactly 5 cycles (4 HOLD + 1 EXPIRED).
REQ-030 Owner 1 drops request after 2 cycles with request=4'b1001 pending -> next edge grant=4'b1000, expired=0, holdCount restarted.
REQ-031 Owner drops with no other request -> next edge grant=0, data=0, pointEnable=0; later request=4'b0001 after lastOwner=3 -> grant=4'b0001.
REQ-032 Assert reset during HOLD of owner 2 with request=4'b1111 -> next edge all outputs zero; release reset -> grant=4'b0001.
REQ-033 Owner 0 changes requestData each cycle -> data tracks with exactly 1-cycle latency; non-owners' changes never appear on data.
